// File: rtl/mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Opcodes, FSM states and the op classification helper.
package mdu_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_md_busy_op(
    input mdu_op_t op
  );
    return op inside {MULT, MULTU, DIV, DIVU};
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Result is computed at issue and committed after a fixed latency.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  mdu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] t_hi_q, t_hi_d;
  logic [31:0] t_lo_q, t_lo_d;
  logic        dz_q, dz_d;

  logic        rt_zero;
  logic signed [63:0] mul_a_s, mul_b_s;
  logic [63:0] prod_s, prod_u;
  logic signed [32:0] div_a_s, div_b_s;
  logic signed [32:0] quo_s, rem_s;
  logic [31:0] div_b_u, quo_u, rem_u;
  logic        unused_div;

  assign rt_zero = (rt_val == 32'd0);

  assign mul_a_s = {{32{rs_val[31]}}, rs_val};
  assign mul_b_s = {{32{rt_val[31]}}, rt_val};
  assign prod_s  = mul_a_s * mul_b_s;
  assign prod_u  = {32'd0, rs_val} * {32'd0, rt_val};

  // 33-bit signed keeps 0x80000000 / -1 well defined; zero divisor is masked
  assign div_a_s = {rs_val[31], rs_val};
  assign div_b_s = rt_zero ? 33'sd1 : {rt_val[31], rt_val};
  assign quo_s   = div_a_s / div_b_s;
  assign rem_s   = div_a_s % div_b_s;

  assign div_b_u = rt_zero ? 32'd1 : rt_val;
  assign quo_u   = rs_val / div_b_u;
  assign rem_u   = rs_val % div_b_u;

  assign unused_div = quo_s[32] ^ rem_s[32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    t_hi_d  = t_hi_q;
    t_lo_d  = t_lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            MULT: begin
              t_hi_d  = prod_s[63:32];
              t_lo_d  = prod_s[31:0];
              dz_d    = 1'b0;
              cnt_d   = MUL_LOAD;
              state_d = S_BUSY;
            end
            MULTU: begin
              t_hi_d  = prod_u[63:32];
              t_lo_d  = prod_u[31:0];
              dz_d    = 1'b0;
              cnt_d   = MUL_LOAD;
              state_d = S_BUSY;
            end
            DIV: begin
              t_hi_d  = rem_s[31:0];
              t_lo_d  = quo_s[31:0];
              dz_d    = rt_zero;
              cnt_d   = DIV_LOAD;
              state_d = S_BUSY;
            end
            DIVU: begin
              t_hi_d  = rem_u;
              t_lo_d  = quo_u;
              dz_d    = rt_zero;
              cnt_d   = DIV_LOAD;
              state_d = S_BUSY;
            end
            MTHI: hi_d = rs_val;
            MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          if (!dz_q) begin
            hi_d = t_hi_q;
            lo_d = t_lo_q;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      t_hi_q  <= '0;
      t_lo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      t_hi_q  <= t_hi_d;
      t_lo_q  <= t_lo_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    busy     = (state_q == S_BUSY);
    md_stall = start & (busy | is_md_busy_op(op));
    hi       = hi_q;
    lo       = lo_q;
    md_out   = '0;
    unique case (op)
      MFHI:    md_out = hi_q;
      MFLO:    md_out = lo_q;
      default: md_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: issue pushes expected HI/LO/latency,
// a monitor pops and compares whenever busy falls.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  mdu_op_t     op;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_stall;
  logic [31:0] md_out, hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
    .md_stall(md_stall), .md_out(md_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: counts busy cycles, compares on busy falling
  initial begin
    int run;
    exp_t e;
    string n;
    run = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got busy run %0d want none", run);
        end else begin
          e = sb_q.pop_front();
          n = nm_q.pop_front();
          chk({n, "_hi"}, hi, e.hi);
          chk({n, "_lo"}, lo, e.lo);
          chk({n, "_cyc"}, 32'(run), e.cyc);
        end
        run = 0;
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] h,
                      input logic [31:0] l, input int c);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.cyc = 32'(c);
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // called at posedge+1; returns at posedge+1 of the acceptance cycle
  task automatic issue(input string nm, input mdu_op_t o,
                       input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    #1;
    chk({nm, "_issue_stall"}, 32'(md_stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = NONE;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy %b want 0", nm, busy);
    end
  endtask

  task automatic single(input mdu_op_t o, input logic [31:0] a);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = NONE;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = NONE;
    rs_val  = '0;
    rt_val  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(md_stall), 32'd0);
    chk("rst_out", md_out, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    push("mult", 32'hFFFFFFFF, 32'hFFFFFFF4, 5);
    issue("mult", MULT, 32'hFFFFFFFD, 32'd4);
    wait_idle("mult");

    push("multu", 32'h00000001, 32'hFFFFFFFE, 5);
    issue("multu", MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu");

    push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue("div", DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div");

    push("divu", 32'h1, 32'h3, 10);
    issue("divu", DIVU, 32'd7, 32'd2);
    wait_idle("divu");

    start  = 1'b1;
    op     = MTHI;
    rs_val = 32'h1234;
    #1;
    chk("mthi_stall", 32'(md_stall), 32'd0);
    @(posedge clk);
    #1;
    op = MFHI;
    #1;
    chk("mfhi_out", md_out, 32'h00001234);
    chk("mfhi_stall", 32'(md_stall), 32'd0);
    start = 1'b0;
    op    = NONE;
    @(posedge clk);
    #1;

    // MFLO held in EX while a DIV is in flight
    push("div100", 32'h2, 32'hE, 10);
    issue("div100", DIV, 32'd100, 32'd7);
    start = 1'b1;
    op    = MFLO;
    for (int i = 0; i < 30 && busy === 1'b1; i++) begin
      #1;
      chk("mflo_stall_busy", 32'(md_stall), 32'd1);
      @(posedge clk);
      #1;
    end
    #1;
    chk("mflo_busy_fell", 32'(busy), 32'd0);
    chk("mflo_stall_free", 32'(md_stall), 32'd0);
    chk("mflo_out", md_out, 32'hE);
    start = 1'b0;
    op    = NONE;
    @(posedge clk);
    #1;

    single(MTHI, 32'd5);
    single(MTLO, 32'd6);
    push("div0", 32'd5, 32'd6, 10);
    issue("div0", DIV, 32'd9, 32'd0);
    wait_idle("div0");
    chk("div0_hi_after", hi, 32'd5);

    // reset in cycle 3 of a MULT discards it
    push("mult_rst", 32'h0, 32'h0, 2);
    issue("mult_rst", MULT, 32'd7, 32'd9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    push("mult23", 32'h0, 32'h6, 5);
    issue("mult23", MULT, 32'd2, 32'd3);
    wait_idle("mult23");

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
